// File: rtl/axi4_sram_slave.sv
// AXI4 responder over a word-addressed SRAM: one read or write transaction at a time, FIXED/INCR bursts.
// Optional wait states before every R beat, W beat and B response: define AXI4_SRAM_DELAY_EN.

module axi4_sram_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    DELAY      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [3:0]            arid_i,
    input  logic [7:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    input  logic [1:0]            arburst_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic [3:0]            rid_o,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [3:0]            awid_i,
    input  logic [7:0]            awlen_i,
    input  logic [2:0]            awsize_i,
    input  logic [1:0]            awburst_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  wlast_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    output logic [3:0]            bid_o
);

    localparam int                    IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDATA = 2'd1,
        WDATA = 2'd2,
        WRESP = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              id_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [7:0]              cnt_q;
    logic                    werr_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   offset_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    err_s;
    logic                    last_s;
    logic                    dly_done_s;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [7:0]              cnt_d;
    logic                    werr_d;
    logic                    ar_hs_s, aw_hs_s, r_hs_s, w_hs_s, b_hs_s, mem_we_s;

    // Offset wraps modulo 2^ADDR_WIDTH, so addresses below the base land out of range too.
    assign offset_s = addr_q - BASE_ADDR;
    assign idx_s    = offset_s[IDX_W+1:2];
    assign err_s    = (offset_s >= MEM_BYTES) | (size_q > 3'd2) | burst_q[1];
    assign last_s   = (cnt_q == len_q);
    assign addr_d   = (burst_q == 2'b01) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;
    assign cnt_d    = cnt_q + 8'd1;
    assign werr_d   = werr_q | err_s;

    assign arready_o = (state_q == IDLE);
    assign awready_o = (state_q == IDLE) & ~arvalid_i;
    assign rvalid_o  = (state_q == RDATA) & dly_done_s;
    assign rdata_o   = ((state_q == RDATA) & ~err_s) ? mem_q[idx_s] : {DATA_WIDTH{1'b0}};
    assign rresp_o   = ((state_q == RDATA) & err_s) ? 2'b10 : 2'b00;
    assign rlast_o   = (state_q == RDATA) & last_s;
    assign rid_o     = (state_q == RDATA) ? id_q : 4'd0;
    assign wready_o  = (state_q == WDATA) & dly_done_s;
    assign bvalid_o  = (state_q == WRESP) & dly_done_s;
    assign bresp_o   = ((state_q == WRESP) & werr_q) ? 2'b10 : 2'b00;
    assign bid_o     = (state_q == WRESP) ? id_q : 4'd0;

    assign ar_hs_s  = arvalid_i & arready_o;
    assign aw_hs_s  = awvalid_i & awready_o;
    assign r_hs_s   = rvalid_o & rready_i;
    assign w_hs_s   = wvalid_i & wready_o;
    assign b_hs_s   = bvalid_o & bready_i;
    assign mem_we_s = w_hs_s & ~err_s & ~rst_i;

`ifdef AXI4_SRAM_DELAY_EN
    logic [7:0] dly_q;

    assign dly_done_s = (dly_q == 8'd0);

    // Wait-state down-counter, reloaded after every handshake on any channel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dly_q <= 8'd0;
        end else if (ar_hs_s | aw_hs_s | r_hs_s | w_hs_s | b_hs_s) begin
            dly_q <= 8'(DELAY);
        end else if (!dly_done_s) begin
            dly_q <= dly_q - 8'd1;
        end else begin
            dly_q <= dly_q;
        end
    end
`else
    assign dly_done_s = (DELAY >= 0);
`endif

    // Byte-enabled SRAM write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with latched request fields and beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= 4'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            cnt_q   <= 8'd0;
            werr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_hs_s) begin
                        addr_q  <= araddr_i;
                        id_q    <= arid_i;
                        len_q   <= arlen_i;
                        size_q  <= arsize_i;
                        burst_q <= arburst_i;
                        cnt_q   <= 8'd0;
                        state_q <= RDATA;
                    end else if (aw_hs_s) begin
                        addr_q  <= awaddr_i;
                        id_q    <= awid_i;
                        len_q   <= awlen_i;
                        size_q  <= awsize_i;
                        burst_q <= awburst_i;
                        cnt_q   <= 8'd0;
                        werr_q  <= 1'b0;
                        state_q <= WDATA;
                    end
                end
                RDATA: begin
                    if (r_hs_s) begin
                        cnt_q  <= cnt_d;
                        addr_q <= addr_d;
                        if (last_s) begin
                            state_q <= IDLE;
                        end
                    end
                end
                WDATA: begin
                    if (w_hs_s) begin
                        cnt_q  <= cnt_d;
                        addr_q <= addr_d;
                        werr_q <= werr_d;
                        if (wlast_i | last_s) begin
                            state_q <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (b_hs_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
AXI4 responder modelling a word-addressed on-chip SRAM. It sits on the slave side of the IFU/LSU read arbiter and serves AR/R and AW/W/B channels, including FIXED and INCR bursts. One transaction is in flight at a time, read or write. It is the terminating endpoint for NPC memory traffic in simulation and FPGA builds.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, address bus width.
DEPTH, 1024, memory size in 32-bit words; must be a power of 2.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
DELAY, 2, extra wait cycles per beat; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
arvalid/arready  in/out  1/1  read address handshake
araddr  in  ADDR_WIDTH  read byte address
arid  in  4  read transaction ID
arlen  in  8  read beats minus 1
arsize  in  3  log2 of bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
rvalid/rready  out/in  1/1  read data handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final read beat
rid  out  4  echo of arid
awvalid/awready  in/out  1/1  write address handshake
awaddr, awid, awlen, awsize, awburst  in  ADDR_WIDTH/4/8/3/2  same meaning as AR
wvalid/wready  in/out  1/1  write data handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  4  byte enables
wlast  in  1  final write beat
bvalid/bready  out/in  1/1  write response handshake
bresp  out  2  write response
bid  out  4  echo of awid

Behaviour:
- FSM states: IDLE, RDATA, WDATA, WRESP. Reset forces IDLE and clears all latched fields and counters. Memory contents are not cleared.
- Output values in IDLE after reset: arready=1; awready=!arvalid; rvalid=wready=bvalid=0; rdata/rresp/rid/bresp/bid=0; rlast=0.
- IDLE:
  - arready=1. awready=1 only when arvalid=0, so reads win a same-cycle tie.
  - ar handshake: latch addr/id/len/size/burst, beat counter=0, go to RDATA.
  - aw handshake, with no ar handshake in the same cycle: latch the AW fields, go to WDATA.
- Error condition (err), evaluated per beat:
  - address outside BASE_ADDR..BASE_ADDR+4*DEPTH-1, or
  - size>2, or
  - burst=WRAP or burst=2'b11.
- RDATA:
  - rvalid=1, rid=latched id, rlast=(count==len).
  - rdata=mem[(addr-BASE_ADDR)>>2], combinational read; rdata=0 when err.
  - rresp=SLVERR when err, else OKAY.
  - On rvalid&rready: count+1; INCR adds addr+=(1<<size); FIXED keeps addr. If rlast, go to IDLE.
  - All outputs stay stable while rready=0.
- WDATA:
  - wready=1.
  - On wvalid: if !err, write each byte i with wstrb[i]=1; accumulate a sticky error flag; advance addr as for reads.
  - Go to WRESP when wlast=1 or count==len, whichever comes first.
  - Beats after the burst has ended are not accepted.
- WRESP: bvalid=1, bid=latched id, bresp=SLVERR if the sticky flag is set, else OKAY. On bready, go to IDLE.
- Latency: ar accepted in cycle N, first rvalid in cycle N+1. Last w accepted in cycle M, bvalid in cycle M+1.
- Address arithmetic is modulo 2^ADDR_WIDTH. Crossing the top of memory mid-burst makes the remaining beats err.
- Reset asserted mid-burst: the next cycle is IDLE, with no further beats or response. Writes already performed persist.

Optional Feature:
AXI4_SRAM_DELAY_EN.
- Defined: each R beat and the B response are preceded by DELAY cycles with rvalid/bvalid=0, counted by a down-counter. wready is also held low for DELAY cycles before each W beat. The counter reloads after every handshake and clears on reset.
- Undefined: zero-wait behaviour as above; the counter logic is absent.

Test Plan:
- Reset, then AR araddr=0x8000_0000, arlen=0, arsize=2, INCR; mem[0]=0x1234_5678 -> one beat rdata=0x1234_5678, rresp=00, rlast=1, rid=arid, in the cycle after the handshake.
- INCR read arlen=3 at 0x8000_0010 with rready toggled every other cycle -> 4 beats mem[4..7] in order, data held while stalled, rlast only on beat 4.
- Write awaddr=0x8000_0020, wdata=0xAABB_CCDD, wstrb=0101 over prior 0x1111_1111 -> bresp=00; readback 0x11BB_11DD.
- arvalid and awvalid in the same IDLE cycle -> read served first, awready=0 that cycle; write accepted after rlast; both complete.
- Read at 0x7FFF_FFFC or with arburst=10 -> rresp=10, rdata=0. Write at 0x9000_0000 -> bresp=10, memory unchanged.
- rst pulsed after beat 2 of a 4-beat read -> next cycle rvalid=0, arready=1; a new read then returns correct data.
